// File: rtl/game_pkg.sv
// Shared game constants: sequencer state encoding, score width, and the
// screen/bird/pipe geometry used by both the game logic and the renderer.
package game_pkg;

  localparam int SCORE_W      = 7;

  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int BIRD_X       = 32;
  localparam int BIRD_SIZE    = 8;
  localparam int PIPE_W       = 16;
  localparam int PIPE_GAP     = 40;
  localparam int PIPE_SPACING = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } game_state_e;

  typedef struct packed {
    logic reset_physics;
    logic reset_score;
    logic run_en;
  } seq_ctrl_t;

  // Control outputs seen while sitting in a given state.
  function automatic seq_ctrl_t ctrl_of(input game_state_e s);
    seq_ctrl_t c;
    c = '{reset_physics: 1'b0, reset_score: 1'b0, run_en: 1'b0};
    case (s)
      IDLE: begin
        c.reset_physics = 1'b1;
        c.reset_score   = 1'b1;
      end
      PLAY:    c.run_en = 1'b1;
      default: c = '{reset_physics: 1'b0, reset_score: 1'b0, run_en: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for the asynchronous button plus a rising-edge detector.
// rise is a single-clk pulse two edges after the first sample; a held button pulses once.
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= btn_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign rise = sync2 & ~sync2_d;

endmodule

// File: rtl/game_sequencer.sv
// Game state sequencer IDLE -> PLAY -> DYING -> OVER -> IDLE with high-score tracking
// and game-over flash; button-to-state latency 3 edges, all outputs registered.
module game_sequencer #(
  parameter int DEATH_FRAMES = 60,
  parameter int BLINK_FRAMES = 15,
  parameter int SCORE_W      = game_pkg::SCORE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_pressed,
  input  logic               frame_tick,
  input  logic               collision,
  input  logic [SCORE_W-1:0] score_in,
  output logic               reset_physics,
  output logic               reset_score,
  output logic               run_en,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] high_score,
  output logic               flash
);

  import game_pkg::*;

  localparam int CNT_MAX = (DEATH_FRAMES > BLINK_FRAMES) ? DEATH_FRAMES : BLINK_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEATH_LAST = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

  game_state_e      state_q;
  seq_ctrl_t        ctrl_q;
  logic [CNT_W-1:0] frame_cnt;
  logic             btn_rise;

  btn_edge_sync u_btn_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (btn_pressed),
    .rise   (btn_rise)
  );

  // Every transition clears frame_cnt, so a tick on an entry edge is never counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ctrl_q     <= ctrl_of(IDLE);
      high_score <= '0;
      frame_cnt  <= '0;
      flash      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (btn_rise) begin
            state_q   <= PLAY;
            ctrl_q    <= ctrl_of(PLAY);
            frame_cnt <= '0;
          end
        end
        PLAY: begin
          if (collision) begin
            state_q   <= DYING;
            ctrl_q    <= ctrl_of(DYING);
            frame_cnt <= '0;
            if (score_in > high_score) high_score <= score_in;
          end
        end
        DYING: begin
          if (frame_tick) begin
            if (frame_cnt == DEATH_LAST) begin
              state_q   <= OVER;
              ctrl_q    <= ctrl_of(OVER);
              frame_cnt <= '0;
              flash     <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        OVER: begin
          if (btn_rise) begin
            state_q   <= IDLE;
            ctrl_q    <= ctrl_of(IDLE);
            frame_cnt <= '0;
            flash     <= 1'b0;
          end else if (frame_tick) begin
            if (frame_cnt == BLINK_LAST) begin
              flash     <= ~flash;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign state         = state_q;
  assign reset_physics = ctrl_q.reset_physics;
  assign reset_score   = ctrl_q.reset_score;
  assign run_en        = ctrl_q.run_en;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized bench for game_sequencer: a per-cycle reference model pushes expected
// outputs into a queue and an independent negedge monitor pops and compares them.
module tb_game_sequencer;

  localparam int DEATH = 60;
  localparam int BLINK = 15;

  logic       clk;
  logic       rst_n;
  logic       btn_pressed;
  logic       frame_tick;
  logic       collision;
  logic [6:0] score_in;
  logic       reset_physics;
  logic       reset_score;
  logic       run_en;
  logic [1:0] state;
  logic [6:0] high_score;
  logic       flash;

  game_sequencer #(.DEATH_FRAMES(DEATH), .BLINK_FRAMES(BLINK), .SCORE_W(7)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_pressed   (btn_pressed),
    .frame_tick    (frame_tick),
    .collision     (collision),
    .score_in      (score_in),
    .reset_physics (reset_physics),
    .reset_score   (reset_score),
    .run_en        (run_en),
    .state         (state),
    .high_score    (high_score),
    .flash         (flash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int hs;
    bit rp;
    bit rs;
    bit run;
    bit fl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: game phase, best score, ticks seen in the current phase,
  // and the raw button samples of the last three edges.
  int m_state;
  int m_hs;
  int m_dticks;
  int m_oticks;
  bit m_hist[3];

  function automatic void model_reset();
    m_state  = 0;
    m_hs     = 0;
    m_dticks = 0;
    m_oticks = 0;
    for (int i = 0; i < 3; i++) m_hist[i] = 1'b0;
  endfunction

  function automatic void model_step(input bit b, input bit t, input bit c, input int s);
    bit rise;
    // A press first sampled two edges ago, not sampled three edges ago.
    rise = m_hist[1] && !m_hist[2];
    case (m_state)
      0: if (rise) m_state = 1;
      1: if (c) begin
           if (s > m_hs) m_hs = s;
           m_state  = 2;
           m_dticks = 0;
         end
      2: if (t) begin
           m_dticks++;
           if (m_dticks == DEATH) begin
             m_state  = 3;
             m_oticks = 0;
           end
         end
      default: if (rise) m_state = 0;
               else if (t) m_oticks++;
    endcase
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = b;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.st  = m_state;
    e.hs  = m_hs;
    e.rp  = (m_state == 0);
    e.rs  = (m_state == 0);
    e.run = (m_state == 1);
    e.fl  = (m_state == 3) && (((m_oticks / BLINK) % 2) == 0);
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("state",         int'(state),         e.st);
      chk("high_score",    int'(high_score),    e.hs);
      chk("reset_physics", int'(reset_physics), int'(e.rp));
      chk("reset_score",   int'(reset_score),   int'(e.rs));
      chk("run_en",        int'(run_en),        int'(e.run));
      chk("flash",         int'(flash),         int'(e.fl));
    end
  end

  task automatic step(input bit b, input bit t, input bit c, input int s);
    btn_pressed = b;
    frame_tick  = t;
    collision   = c;
    score_in    = 7'(s);
    @(posedge clk);
    model_step(b, t, c, s);
    push_exp();
    @(negedge clk);
  endtask

  // Reset asserted between edges so the following negedge check proves it is asynchronous.
  task automatic hold_reset(input int n);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    push_exp();
    repeat (n) begin
      @(posedge clk);
      push_exp();
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic bit rbit(input int pct);
    return ($urandom_range(99, 0) < pct);
  endfunction

  task automatic idle(input int n);
    repeat (n) step(1'b0, rbit(30), rbit(20), int'($urandom_range(127, 0)));
  endtask

  task automatic press(input int n);
    repeat (n) step(1'b1, rbit(30), 1'b0, int'($urandom_range(127, 0)));
  endtask

  task automatic ticks(input int n, input int gap, input bit poke_btn);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap, 0))
        step(poke_btn && rbit(30), 1'b0, rbit(20), int'($urandom_range(127, 0)));
      step(poke_btn && rbit(30), 1'b1, rbit(20), int'($urandom_range(127, 0)));
    end
  endtask

  task automatic play_game(input int score);
    press(5);
    repeat (4) step(1'b0, rbit(30), 1'b0, int'($urandom_range(127, 0)));
    repeat ($urandom_range(15, 2)) step(1'b0, rbit(30), 1'b0, score);
    step(1'b0, 1'b0, 1'b1, score);
    ticks(DEATH - 5, 2, 1'b1);
    ticks(5, 2, 1'b0);
    idle(4);
    ticks(BLINK, 1, 1'b0);
    ticks(BLINK, 1, 1'b0);
    press(12);
    step(1'b0, 1'b0, 1'b0, 0);
    idle(3);
  endtask

  initial begin
    rst_n       = 1'b0;
    btn_pressed = 1'b0;
    frame_tick  = 1'b0;
    collision   = 1'b0;
    score_in    = '0;
    model_reset();
    @(negedge clk);
    hold_reset(2);
    idle(3);

    play_game(12);
    play_game(12);
    play_game(5);
    play_game(13);

    // Collision, button edge and frame tick all land on the same PLAY edge.
    press(4);
    repeat (6) step(1'b0, 1'b0, 1'b0, 20);
    step(1'b1, 1'b0, 1'b0, 20);
    step(1'b1, 1'b0, 1'b0, 20);
    step(1'b1, 1'b1, 1'b1, 20);
    step(1'b0, 1'b0, 1'b0, 0);
    ticks(DEATH - 1, 1, 1'b0);
    idle(2);
    ticks(1, 0, 1'b0);
    idle(2);
    press(3);
    step(1'b0, 1'b0, 1'b0, 0);
    idle(3);

    // Reset dropped in the middle of DYING.
    press(4);
    repeat (5) step(1'b0, 1'b0, 1'b0, 30);
    step(1'b0, 1'b0, 1'b1, 30);
    ticks(10, 1, 1'b0);
    hold_reset(2);
    idle(5);

    // Free-running random traffic, including occasional resets.
    begin
      bit b;
      b = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        if (rbit(6)) b = ~b;
        step(b, rbit(35), rbit(4), int'($urandom_range(127, 0)));
        if (i % 1500 == 1499) hold_reset(1);
      end
    end

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low, ports named clk and rst_n.
REQ-002 Parameters SHALL be, one per line (name, default, meaning):
- DEATH_FRAMES, 60, frame ticks spent frozen in DYING.
- BLINK_FRAMES, 15, frame ticks per half-period of the game-over flash.
- SCORE_W, 7, score width.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, system clock.
- rst_n, in, 1, async active-low reset.
- btn_pressed, in, 1, raw button level, asynchronous to clk.
- frame_tick, in, 1, one-clk pulse per game frame from the clock divider.
- collision, in, 1, level from the pipe/bird overlap logic, valid every clk.
- score_in, in, SCORE_W, current score from the obstacle generator.
- reset_physics, out, 1, holds the obstacle generator and bird position in their start state.
- reset_score, out, 1, clears the obstacle generator score.
- run_en, out, 1, gate for the game-frame clock enable; 1 only while playing.
- state, out, 2, current state encoding.
- high_score, out, SCORE_W, best score since reset.
- flash, out, 1, game-over blink for the display.

Function
REQ-004 The block SHALL implement four states: IDLE=0, PLAY=1, DYING=2, OVER=3.
REQ-005 btn_pressed SHALL pass through a 2-flop synchronizer and a rising-edge detector; btn_rise SHALL be a one-clk pulse, and a held button SHALL produce exactly one pulse.
REQ-006 A btn_pressed rising edge sampled at clk edge N SHALL make the state change visible after edge N+2 (3-cycle latency).
REQ-007 In IDLE the outputs SHALL be reset_physics=1, reset_score=1, run_en=0 and flash=0; btn_rise SHALL move IDLE to PLAY.
REQ-008 In PLAY the outputs SHALL be reset_physics=0, reset_score=0 and run_en=1; collision=1 sampled on a clk edge SHALL move PLAY to DYING on that edge.
REQ-009 On the PLAY to DYING edge, high_score SHALL load score_in if score_in > high_score (unsigned), and SHALL otherwise be unchanged; equal scores SHALL NOT update it.
REQ-010 In DYING the outputs SHALL be run_en=0, reset_physics=0 and reset_score=0, so the last frame stays frozen on screen.
REQ-011 In DYING a frame counter SHALL count frame_tick pulses; when the count reaches DEATH_FRAMES the state SHALL move to OVER; btn_rise SHALL be ignored.
REQ-012 In OVER the outputs SHALL be run_en=0 and reset_physics=0; flash SHALL toggle every BLINK_FRAMES frame_tick pulses, starting at 1 on entry; btn_rise SHALL move the state to IDLE.
REQ-013 On leaving OVER, flash SHALL return to 0 and the frame counter SHALL clear.
REQ-014 Boundary and simultaneous-event rules:
- A frame_tick on the same edge as entry to DYING or OVER SHALL NOT be counted.
- collision and btn_rise on the same edge in PLAY: collision wins.
- collision in any state other than PLAY SHALL be ignored.
- The frame counter SHALL be wide enough for max(DEATH_FRAMES, BLINK_FRAMES) and SHALL clear on every state change.
- A button held from OVER into IDLE SHALL NOT start play; a new press is required.
REQ-015 All outputs SHALL be registered or decoded only from registered state, with no combinational path from any input to any output.

Reset
REQ-016 While rst_n=0 the block SHALL be held as follows:
- state=IDLE, reset_physics=1, reset_score=1, run_en=0, flash=0;
- high_score=0, frame counter=0, synchronizer and edge flops=0.
REQ-017 Assertion of rst_n mid-operation, in any state, SHALL return the block to IDLE immediately (asynchronously); high_score is cleared only by rst_n.
REQ-018 Deassertion of rst_n SHALL take effect on the next clk edge.

Structure
REQ-019 A shared package game_pkg SHALL hold:
- the state encoding constants (IDLE, PLAY, DYING, OVER);
- SCORE_W;
- the screen, bird and pipe geometry constants shared with the game and renderer.
REQ-020 The synchronizer plus edge detector SHALL be one sub-module, btn_edge_sync (ports clk, rst_n, btn_in, rise); the rest SHALL be flat.

Verification
REQ-021 Start: after reset, assert btn_pressed for 5 clks -> state=PLAY after 3 edges, run_en=1, reset_physics=0, and exactly one transition occurs.
REQ-022 Collision: in PLAY with score_in=12 and high_score=0, pulse collision for 1 clk -> state=DYING next edge, high_score=12, run_en=0; then 60 frame_ticks -> OVER, and flash=1 on entry.
REQ-023 High-score hold: a second game dies with score_in=12, then a third with 5 -> high_score stays 12 after both; a fourth with 13 -> high_score=13.
REQ-024 Ignore rules: btn pulses during DYING -> no state change; in OVER, 15 frame_ticks -> flash toggles to 0, 30 -> flash back to 1; btn -> IDLE with flash=0; a held button -> stays IDLE.
REQ-025 Simultaneous events: collision and btn edge on the same PLAY cycle -> DYING; a frame_tick coincident with DYING entry is not counted (OVER after the 61st tick since that edge minus the coincident one).
REQ-026 Reset mid-DYING: drop rst_n for 2 clks -> immediately IDLE, reset_physics=1, high_score=0, counter=0.
